// File: rtl/fixed_point_divider.sv
// fixed_point_divider: sequential signed fixed-point divider (in1 / in2).
// A restoring divider produces one magnitude quotient bit per cycle. The
// result is then re-signed and saturated to a WIO.WFO output format.
// Handshake: start is sampled only in IDLE. busy is high from the accept
// edge through the done cycle. done is a one-cycle pulse, and the result
// outputs are valid from that cycle until the next done.
module fixed_point_divider #(
  parameter int WI1 = 3,
  parameter int WF1 = 4,
  parameter int WI2 = 4,
  parameter int WF2 = 3,
  parameter int WIO = 4,
  parameter int WFO = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic signed [WI1+WF1-1:0]   in1,
  input  logic signed [WI2+WF2-1:0]   in2,
  output logic                        busy,
  output logic                        done,
  output logic signed [WIO+WFO-1:0]   FixedPoint_Div_Out,
  output logic                        overFlow,
  output logic                        divZero,
  output logic [1:0]                  o_dbg_state
);

  localparam int W1 = WI1 + WF1;
  localparam int W2 = WI2 + WF2;
  localparam int W  = WIO + WFO;
  localparam int S  = WFO + WF2 - WF1;   // pre-shift that aligns the quotient to WFO
  localparam int NW = WI1 + WF1 + S;     // numerator width and iteration count
  localparam int RW = W2 + 1;            // remainder width: shifted remainder < 2*D
  localparam int CW = $clog2(NW + 1);
  localparam int XW = NW + W + 1;        // width wide enough for the saturation compare

  if (S < 0) begin : g_bad_shift
    $error("fixed_point_divider: WFO + WF2 - WF1 must be >= 0");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    r_state;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_out;
  logic          r_ovf;
  logic          r_dz;
  logic          r_sgn;
  logic          r_zero;
  logic [NW-1:0] r_n;      // numerator, which fills up with quotient bits
  logic [RW-1:0] r_d;
  logic [RW-1:0] r_r;
  logic [CW-1:0] r_cnt;

  // Operand magnitudes, computed one bit wider so the most-negative input negates correctly.
  logic [W1:0]   w_in1_ext;
  logic [W1:0]   w_abs1;
  logic [W2:0]   w_in2_ext;
  logic [RW-1:0] w_abs2;
  logic [NW-1:0] w_n0;
  logic          w_in2_zero;

  assign w_in1_ext  = {in1[W1-1], in1};
  assign w_abs1     = in1[W1-1] ? -w_in1_ext : w_in1_ext;
  assign w_in2_ext  = {in2[W2-1], in2};
  assign w_abs2     = in2[W2-1] ? -w_in2_ext : w_in2_ext;
  assign w_n0       = NW'(w_abs1) << S;
  assign w_in2_zero = (in2 == '0);

  // One restoring step: shift the next numerator bit into the remainder, then trial-subtract.
  logic [RW-1:0] w_r_sh;
  logic          w_qbit;
  logic [RW-1:0] w_r_next;

  assign w_r_sh   = {r_r[RW-2:0], r_n[NW-1]};
  assign w_qbit   = (w_r_sh >= r_d);
  assign w_r_next = w_qbit ? (w_r_sh - r_d) : w_r_sh;

  // Result formatting: the negative range reaches one count further than the positive range.
  logic [XW-1:0] w_q_x;
  logic [XW-1:0] w_lim;
  logic [W-1:0]  w_q_w;
  logic [W-1:0]  w_max_pos;
  logic [W-1:0]  w_min_neg;

  assign w_q_x     = XW'(r_n);
  assign w_lim     = (XW'(1) << (W - 1)) - {{(XW-1){1'b0}}, ~r_sgn};
  assign w_q_w     = w_q_x[W-1:0];
  assign w_max_pos = {1'b0, {(W-1){1'b1}}};
  assign w_min_neg = {1'b1, {(W-1){1'b0}}};

  // Control FSM and datapath registers.
  // DONE first waits for r_cnt to reach 0. It then registers the result and raises done.
  // It returns to IDLE one cycle later, so done never overlaps IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
      r_sgn   <= 1'b0;
      r_zero  <= 1'b0;
      r_n     <= '0;
      r_d     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_r    <= '0;
            if (w_in2_zero) begin
              // A zero divisor skips the iterations. One wait cycle in DONE gives a two-cycle latency.
              r_state <= DONE;
              r_zero  <= 1'b1;
              r_sgn   <= in1[W1-1];
              r_n     <= '0;
              r_d     <= '0;
              r_cnt   <= CW'(1);
            end else begin
              r_state <= DIV;
              r_zero  <= 1'b0;
              r_sgn   <= in1[W1-1] ^ in2[W2-1];
              r_n     <= w_n0;
              r_d     <= w_abs2;
              r_cnt   <= CW'(NW - 1);
            end
          end
        end
        DIV: begin
          r_r <= w_r_next;
          r_n <= {r_n[NW-2:0], w_qbit};
          if (r_cnt == '0) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (r_done) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_done <= 1'b1;
            if (r_zero) begin
              r_out <= r_sgn ? w_min_neg : w_max_pos;
              r_ovf <= 1'b1;
              r_dz  <= 1'b1;
            end else if (w_q_x > w_lim) begin
              r_out <= r_sgn ? w_min_neg : w_max_pos;
              r_ovf <= 1'b1;
              r_dz  <= 1'b0;
            end else begin
              r_out <= r_sgn ? -w_q_w : w_q_w;
              r_ovf <= 1'b0;
              r_dz  <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy               = r_busy;
  assign done               = r_done;
  assign FixedPoint_Div_Out = r_out;
  assign overFlow           = r_ovf;
  assign divZero            = r_dz;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed testbench for fixed_point_divider with default parameters (Q3.4 / Q4.3 -> Q4.4).
module tb_fixed_point_divider;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic signed [6:0] in1;
  logic signed [6:0] in2;
  logic              busy;
  logic              done;
  logic signed [7:0] dout;
  logic              overflow;
  logic              divzero;
  logic [1:0]        dbg_state;

  int n_checks;
  int n_fail;

  fixed_point_divider dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .in1                (in1),
    .in2                (in2),
    .busy               (busy),
    .done               (done),
    .FixedPoint_Div_Out (dout),
    .overFlow           (overflow),
    .divZero            (divzero),
    .o_dbg_state        (dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request from a point away from the clock edge. Returns the cycles from the
  // accept edge to the first done, or 0 if done never arrives within the bound.
  // busy_ok is cleared if busy drops before done.
  task automatic run_div(input logic [6:0] a, input logic [6:0] b,
                         output int lat, output logic busy_ok);
    in1 = a;
    in2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_ok = busy;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    in1 = '0;
    in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_out got=%h exp=00", dout); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    n_checks++; if (divzero !== 1'b0) begin n_fail++; $display("FAIL reset_dz got=%b exp=0", divzero); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_positive();
    int lat;
    logic bok;
    run_div(7'h28, 7'h0C, lat, bok);
    n_checks++; if (lat != 11) begin n_fail++; $display("FAIL pos_latency got=%0d exp=11", lat); end
    n_checks++; if (dout !== 8'h1A) begin n_fail++; $display("FAIL pos_out got=%h exp=1a", dout); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pos_ovf got=%b exp=0", overflow); end
    n_checks++; if (divzero !== 1'b0) begin n_fail++; $display("FAIL pos_dz got=%b exp=0", divzero); end
    n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL pos_busy_held got=%b exp=1", bok); end
    @(posedge clk);
    #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL pos_done_pulse got=%b exp=0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pos_busy_after got=%b exp=0", busy); end
    n_checks++; if (dout !== 8'h1A) begin n_fail++; $display("FAIL pos_out_hold got=%h exp=1a", dout); end
  endtask

  task automatic test_sign_saturation();
    logic [6:0] va [4] = '{7'h58, 7'h40, 7'h3F, 7'h3F};
    logic [6:0] vb [4] = '{7'h0C, 7'h04, 7'h01, 7'h7F};
    logic [7:0] vq [4] = '{8'hE6, 8'h80, 8'h7F, 8'h80};
    logic       vo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    logic bok;
    for (int i = 0; i < 4; i++) begin
      run_div(va[i], vb[i], lat, bok);
      n_checks++; if (lat != 11) begin n_fail++; $display("FAIL sign%0d_latency got=%0d exp=11", i, lat); end
      n_checks++; if (dout !== vq[i]) begin n_fail++; $display("FAIL sign%0d_out got=%h exp=%h", i, dout, vq[i]); end
      n_checks++; if (overflow !== vo[i]) begin n_fail++; $display("FAIL sign%0d_ovf got=%b exp=%b", i, overflow, vo[i]); end
      n_checks++; if (divzero !== 1'b0) begin n_fail++; $display("FAIL sign%0d_dz got=%b exp=0", i, divzero); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div_zero();
    logic [6:0] va [2] = '{7'h70, 7'h00};
    logic [7:0] vq [2] = '{8'h80, 8'h7F};
    int lat;
    logic bok;
    for (int i = 0; i < 2; i++) begin
      run_div(va[i], 7'h00, lat, bok);
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL dz%0d_latency got=%0d exp=2", i, lat); end
      n_checks++; if (dout !== vq[i]) begin n_fail++; $display("FAIL dz%0d_out got=%h exp=%h", i, dout, vq[i]); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL dz%0d_ovf got=%b exp=1", i, overflow); end
      n_checks++; if (divzero !== 1'b1) begin n_fail++; $display("FAIL dz%0d_dz got=%b exp=1", i, divzero); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int n_done;
    logic bok;
    in1 = 7'h28;
    in2 = 7'h0C;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    n_done = 0;
    for (int c = 1; c <= 40; c++) begin
      // Extra requests land on edges 3 and 5 while busy, with operands that would saturate.
      start = (c == 2 || c == 4);
      in1 = 7'h3F;
      in2 = 7'h01;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        n_done++;
        lat = c;
        break;
      end
    end
    n_checks++; if (lat != 11) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=11", lat); end
    n_checks++; if (dout !== 8'h1A) begin n_fail++; $display("FAIL b2b_first_out got=%h exp=1a", dout); end
    @(posedge clk);
    #1;
    if (done) n_done++;
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=1", n_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    run_div(7'h58, 7'h0C, lat, bok);
    n_checks++; if (lat != 11) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=11", lat); end
    n_checks++; if (dout !== 8'hE6) begin n_fail++; $display("FAIL b2b_second_out got=%h exp=e6", dout); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int n_done;
    logic bok;
    in1 = 7'h28;
    in2 = 7'h0C;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL midrst_out got=%h exp=00", dout); end
    n_checks++; if (overflow !== 1'b0 || divzero !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flags got=%b%b%b exp=000", overflow, divzero, done);
    end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL midrst_state got=%0d exp=0", dbg_state); end
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", n_done); end
    run_div(7'h28, 7'h0C, lat, bok);
    n_checks++; if (lat != 11) begin n_fail++; $display("FAIL midrst_fresh_latency got=%0d exp=11", lat); end
    n_checks++; if (dout !== 8'h1A) begin n_fail++; $display("FAIL midrst_fresh_out got=%h exp=1a", dout); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_positive();
    test_sign_saturation();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
